// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: instruction fields and status flags in, datapath/memory controls out.
interface multicycle_control_unit_if #(
    parameter int unsigned ALUCTRL_W = 3
);
    // Instruction register fields and datapath status
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 zero;
    logic                 mem_ready;

    // Memory port controls
    logic                 mem_req;
    logic                 memwrite;
    logic                 iord;
    logic                 irwrite;

    // Register file / ALU / PC controls
    logic                 regdst;
    logic                 memtoreg;
    logic                 regwrite;
    logic                 alusrca;
    logic [1:0]           alusrcb;
    logic [1:0]           pcsrc;
    logic                 pc_en;
    logic [ALUCTRL_W-1:0] alucontrol;

    // Debug and sticky status
    logic [3:0]           state;
    logic                 illegal;
    logic                 bus_error;

    // Control unit side
    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pc_en, alucontrol, state, illegal, bus_error
    );

    // Datapath / memory side
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pc_en, alucontrol, state, illegal, bus_error
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control: Moore FSM sequencing fetch/decode/execute over a shared
// ALU and unified memory port, with a bounded memory-ready wait and sticky error flags.
module multicycle_control_unit #(
    parameter int unsigned ALUCTRL_W    = 3,
    parameter bit          ENABLE_BNE   = 1'b1,
    parameter bit          ENABLE_JUMP  = 1'b1,
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_unit_if.master   bus
);

    // Wait counter only needs to reach WAIT_TIMEOUT-1 before the timeout fires
    localparam int unsigned CNT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b110);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b111);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t               cur_state;
    state_t               next_state;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 illegal_flag;
    logic                 bus_error_flag;
    logic                 set_illegal;
    logic                 set_bus_error;
    logic                 waiting;
    logic                 timeout;
    logic                 funct_ok;
    logic [ALUCTRL_W-1:0] funct_alu;
    logic                 pc_en_raw;
    logic                 irwrite_raw;

    // R-type funct to ALU operation; undecodable functs flagged for the illegal path
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // Memory states stall on mem_ready; a ready arriving on the last allowed cycle still wins
    assign waiting = ((cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR))
                     && !bus.mem_ready;
    assign timeout = (WAIT_TIMEOUT != 0) && waiting
                     && (wait_cnt == CNT_W'(WAIT_TIMEOUT - 32'd1));

    // Next-state and Moore control decode
    always_comb begin
        next_state    = cur_state;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        bus.mem_req    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.iord       = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.alucontrol = ALU_ADD;
        pc_en_raw      = 1'b0;
        irwrite_raw    = 1'b0;

        case (cur_state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.alusrcb = 2'b01;
                irwrite_raw = bus.mem_ready;
                pc_en_raw   = bus.mem_ready;
                if (bus.mem_ready) begin
                    next_state = S_DECODE;
                end else if (timeout) begin
                    next_state    = S_FETCH;
                    set_bus_error = 1'b1;
                end
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_BNE: begin
                        if (ENABLE_BNE) begin
                            next_state = S_BRANCH;
                        end else begin
                            next_state  = S_FETCH;
                            set_illegal = 1'b1;
                        end
                    end
                    OP_J: begin
                        if (ENABLE_JUMP) begin
                            next_state = S_JUMP;
                        end else begin
                            next_state  = S_FETCH;
                            set_illegal = 1'b1;
                        end
                    end
                    default: begin
                        next_state  = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                next_state  = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) begin
                    next_state = S_MEMWB;
                end else if (timeout) begin
                    next_state    = S_FETCH;
                    set_bus_error = 1'b1;
                end
            end
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
                next_state   = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) begin
                    next_state = S_FETCH;
                end else if (timeout) begin
                    next_state    = S_FETCH;
                    set_bus_error = 1'b1;
                end
            end
            S_EXEC: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = funct_alu;
                if (funct_ok) begin
                    next_state = S_ALUWB;
                end else begin
                    next_state  = S_FETCH;
                    set_illegal = 1'b1;
                end
            end
            S_ALUWB: begin
                bus.regwrite   = 1'b1;
                bus.regdst     = 1'b1;
                bus.alucontrol = funct_alu;
                next_state     = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = ALU_SUB;
                bus.pcsrc      = 2'b01;
                if (ENABLE_BNE && (bus.opcode == OP_BNE)) begin
                    pc_en_raw = !bus.zero;
                end else begin
                    pc_en_raw = bus.zero;
                end
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                next_state  = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.regwrite = 1'b1;
                next_state   = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsrc  = 2'b10;
                pc_en_raw  = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // PC and IR updates are suppressed while reset is held
    assign bus.pc_en     = pc_en_raw & ~reset;
    assign bus.irwrite   = irwrite_raw & ~reset;
    assign bus.state     = cur_state;
    assign bus.illegal   = illegal_flag;
    assign bus.bus_error = bus_error_flag;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Consecutive wait-cycle counter; restarts on any state change or timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((next_state != cur_state) || timeout) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_flag   <= 1'b0;
            bus_error_flag <= 1'b0;
        end else begin
            if (set_illegal) begin
                illegal_flag <= 1'b1;
            end
            if (set_bus_error) begin
                bus_error_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus queues per-cycle expected controls,
// a negedge monitor pops and compares them against the live outputs.
module tb_multicycle_control_unit;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pc_en;
        logic [2:0] alu;
        logic       illegal;
        logic       bus_error;
    } exp_t;

    logic clk;
    logic reset;
    logic reset1;
    int   total;
    int   bad;

    exp_t  exp_q[$];
    string lbl_q[$];

    logic       rst_v;
    logic       z_v;
    logic [5:0] op_v;
    logic [5:0] fn_v;
    logic       ill_v;
    logic       be_v;

    multicycle_control_unit_if #(.ALUCTRL_W(3)) bus0 ();
    multicycle_control_unit_if #(.ALUCTRL_W(3)) bus1 ();

    multicycle_control_unit #(
        .ALUCTRL_W(3), .ENABLE_BNE(1'b1), .ENABLE_JUMP(1'b1), .WAIT_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    multicycle_control_unit #(
        .ALUCTRL_W(3), .ENABLE_BNE(1'b0), .ENABLE_JUMP(1'b0), .WAIT_TIMEOUT(15)
    ) dut_min (
        .clk(clk), .reset(reset1), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Static control values each state must present (hand-written from the state table)
    function automatic exp_t base(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.state = st;
        e.alu   = ADD;
        case (st)
            4'd0:  begin e.mem_req = 1'b1; e.alusrcb = 2'b01; end
            4'd1:  begin e.alusrcb = 2'b11; end
            4'd2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd3:  begin e.mem_req = 1'b1; e.iord = 1'b1; end
            4'd4:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            4'd5:  begin e.mem_req = 1'b1; e.memwrite = 1'b1; e.iord = 1'b1; end
            4'd6:  begin e.alusrca = 1'b1; end
            4'd7:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            4'd8:  begin e.alusrca = 1'b1; e.pcsrc = 2'b01; end
            4'd9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd10: begin e.regwrite = 1'b1; end
            4'd11: begin e.pcsrc = 2'b10; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Drive one cycle of inputs and queue the expected outputs for that cycle
    task automatic step(input string lbl, input logic mr, input logic [3:0] st,
                        input logic pe, input logic irw, input logic [2:0] alu);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst_v;
        bus0.mem_ready = mr;
        bus0.zero      = z_v;
        bus0.opcode    = op_v;
        bus0.funct     = fn_v;
        e = base(st);
        e.pc_en     = pe;
        e.irwrite   = irw;
        e.alu       = alu;
        e.illegal   = ill_v;
        e.bus_error = be_v;
        exp_q.push_back(e);
        lbl_q.push_back(lbl);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, want);
        end
    endtask

    // Fetch + decode pair with mem_ready high
    task automatic fd(input string n);
        step({n, "_fetch"}, 1'b1, 4'd0, 1'b1, 1'b1, ADD);
        step({n, "_decode"}, 1'b1, 4'd1, 1'b0, 1'b0, ADD);
    endtask

    // Monitor: compare every queued cycle at the falling edge
    exp_t  mon_e;
    exp_t  mon_a;
    string mon_l;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_l = lbl_q.pop_front();
                mon_a.state     = bus0.state;
                mon_a.mem_req   = bus0.mem_req;
                mon_a.memwrite  = bus0.memwrite;
                mon_a.iord      = bus0.iord;
                mon_a.irwrite   = bus0.irwrite;
                mon_a.regdst    = bus0.regdst;
                mon_a.memtoreg  = bus0.memtoreg;
                mon_a.regwrite  = bus0.regwrite;
                mon_a.alusrca   = bus0.alusrca;
                mon_a.alusrcb   = bus0.alusrcb;
                mon_a.pcsrc     = bus0.pcsrc;
                mon_a.pc_en     = bus0.pc_en;
                mon_a.alu       = bus0.alucontrol;
                mon_a.illegal   = bus0.illegal;
                mon_a.bus_error = bus0.bus_error;
                total++;
                if (mon_a !== mon_e) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", mon_l, mon_a, mon_e);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; reset1 = 1'b1; rst_v = 1'b1;
        z_v = 1'b0; op_v = OP_LW; fn_v = 6'b000000; ill_v = 1'b0; be_v = 1'b0;
        bus0.mem_ready = 1'b1; bus0.zero = 1'b0; bus0.opcode = OP_LW; bus0.funct = 6'b0;
        bus1.mem_ready = 1'b1; bus1.zero = 1'b0; bus1.opcode = OP_BNE; bus1.funct = 6'b0;

        // Reset state: FETCH decode but PC/IR writes held off
        #2;
        chk("reset_state", 32'(bus0.state), 32'd0);
        chk("reset_pc_en", 32'(bus0.pc_en), 32'd0);
        chk("reset_irwrite", 32'(bus0.irwrite), 32'd0);
        chk("reset_mem_req", 32'(bus0.mem_req), 32'd1);
        step("reset_hold", 1'b1, 4'd0, 1'b0, 1'b0, ADD);

        // lw: one fetch wait then 0,1,2,3,4
        rst_v = 1'b0; op_v = OP_LW;
        step("lw_fetch_wait", 1'b0, 4'd0, 1'b0, 1'b0, ADD);
        fd("lw");
        step("lw_memadr", 1'b1, 4'd2, 1'b0, 1'b0, ADD);
        step("lw_memrd", 1'b1, 4'd3, 1'b0, 1'b0, ADD);
        step("lw_memwb", 1'b1, 4'd4, 1'b0, 1'b0, ADD);

        // sw: 0,1,2,5
        op_v = OP_SW;
        fd("sw");
        step("sw_memadr", 1'b1, 4'd2, 1'b0, 1'b0, ADD);
        step("sw_memwr", 1'b1, 4'd5, 1'b0, 1'b0, ADD);

        // R-type sub
        op_v = OP_RTYPE; fn_v = 6'b100010;
        fd("sub");
        step("sub_exec", 1'b1, 4'd6, 1'b0, 1'b0, SUB);
        step("sub_aluwb", 1'b1, 4'd7, 1'b0, 1'b0, SUB);

        // R-type slt
        fn_v = 6'b101010;
        fd("slt");
        step("slt_exec", 1'b1, 4'd6, 1'b0, 1'b0, 3'b111);
        step("slt_aluwb", 1'b1, 4'd7, 1'b0, 1'b0, 3'b111);

        // addi
        op_v = OP_ADDI;
        fd("addi");
        step("addi_ex", 1'b1, 4'd9, 1'b0, 1'b0, ADD);
        step("addi_wb", 1'b1, 4'd10, 1'b0, 1'b0, ADD);

        // beq taken / not taken
        op_v = OP_BEQ; z_v = 1'b1;
        fd("beq_t");
        step("beq_taken", 1'b1, 4'd8, 1'b1, 1'b0, SUB);
        z_v = 1'b0;
        fd("beq_n");
        step("beq_not_taken", 1'b1, 4'd8, 1'b0, 1'b0, SUB);

        // bne taken (zero=0) / not taken (zero=1)
        op_v = OP_BNE; z_v = 1'b0;
        fd("bne_t");
        step("bne_taken", 1'b1, 4'd8, 1'b1, 1'b0, SUB);
        z_v = 1'b1;
        fd("bne_n");
        step("bne_not_taken", 1'b1, 4'd8, 1'b0, 1'b0, SUB);
        z_v = 1'b0;

        // j
        op_v = OP_J;
        fd("j");
        step("j_jump", 1'b1, 4'd11, 1'b1, 1'b0, ADD);

        // sw with mem_ready low 3 cycles
        op_v = OP_SW;
        fd("sw3");
        step("sw3_memadr", 1'b1, 4'd2, 1'b0, 1'b0, ADD);
        for (int i = 0; i < 3; i++) step("sw3_wait", 1'b0, 4'd5, 1'b0, 1'b0, ADD);
        step("sw3_done", 1'b1, 4'd5, 1'b0, 1'b0, ADD);

        // sw: ready arrives on the 15th wait cycle, completes without error
        fd("sw15");
        step("sw15_memadr", 1'b1, 4'd2, 1'b0, 1'b0, ADD);
        for (int i = 0; i < 14; i++) step("sw15_wait", 1'b0, 4'd5, 1'b0, 1'b0, ADD);
        step("sw15_ready_at_limit", 1'b1, 4'd5, 1'b0, 1'b0, ADD);

        // sw timeout: 15 low cycles then FETCH with bus_error
        fd("swto");
        step("swto_memadr", 1'b1, 4'd2, 1'b0, 1'b0, ADD);
        for (int i = 0; i < 15; i++) step("swto_wait", 1'b0, 4'd5, 1'b0, 1'b0, ADD);
        be_v = 1'b1;

        // Bad funct after timeout: fetch shows memwrite dropped and bus_error set
        op_v = OP_RTYPE; fn_v = 6'b000111;
        fd("badfn");
        step("badfn_exec", 1'b1, 4'd6, 1'b0, 1'b0, ADD);
        ill_v = 1'b1;
        step("badfn_fetch_wait", 1'b0, 4'd0, 1'b0, 1'b0, ADD);

        // lw aborted by asynchronous reset mid-MEMRD
        op_v = OP_LW;
        fd("lwrst");
        step("lwrst_memadr", 1'b1, 4'd2, 1'b0, 1'b0, ADD);
        step("lwrst_memrd", 1'b0, 4'd3, 1'b0, 1'b0, ADD);
        #6;
        bus0.mem_ready = 1'b1;
        reset = 1'b1; rst_v = 1'b1;
        #1;
        chk("async_reset_state", 32'(bus0.state), 32'd0);
        chk("async_reset_illegal", 32'(bus0.illegal), 32'd0);
        chk("async_reset_bus_error", 32'(bus0.bus_error), 32'd0);
        chk("async_reset_pc_en", 32'(bus0.pc_en), 32'd0);
        chk("async_reset_irwrite", 32'(bus0.irwrite), 32'd0);
        chk("async_reset_iord", 32'(bus0.iord), 32'd0);
        ill_v = 1'b0; be_v = 1'b0;
        step("reset_held_1", 1'b1, 4'd0, 1'b0, 1'b0, ADD);
        step("reset_held_2", 1'b1, 4'd0, 1'b0, 1'b0, ADD);

        // Unknown opcode sets illegal and returns to FETCH
        rst_v = 1'b0; op_v = OP_BAD;
        fd("badop");
        ill_v = 1'b1;
        step("badop_fetch", 1'b0, 4'd0, 1'b0, 1'b0, ADD);

        // Let the monitor drain, bounded
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        // Reduced-ISA instance: BNE and J decode as illegal
        #1;
        reset1 = 1'b0;
        @(posedge clk); #1;
        chk("min_bne_decode", 32'(bus1.state), 32'd1);
        @(posedge clk); #1;
        chk("min_bne_to_fetch", 32'(bus1.state), 32'd0);
        chk("min_bne_illegal", 32'(bus1.illegal), 32'd1);
        reset1 = 1'b1;
        #1;
        chk("min_reset_clears_illegal", 32'(bus1.illegal), 32'd0);
        bus1.opcode = OP_J;
        @(posedge clk); #1;
        reset1 = 1'b0;
        @(posedge clk); #1;
        chk("min_j_decode", 32'(bus1.state), 32'd1);
        @(posedge clk); #1;
        chk("min_j_to_fetch", 32'(bus1.state), 32'd0);
        chk("min_j_illegal", 32'(bus1.illegal), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
